fir_seq_ctrl: RTL and testbench

- Control sequencer for the single-multiplier, single-adder FIR engine.
- Owns the ap_start/ap_done/ap_idle lifecycle and accepts input samples over the AXI-Stream slave handshake.
- Drives tap-RAM and data-RAM addresses/enables for an 11-tap circular-buffer convolution, and sequences the MAC datapath.
- Releases each result over the AXI-Stream master handshake. Sits between the AXI-lite register file and the MAC datapath/BRAM pair.

---
 rtl/fir_pkg.sv | 21 ++
 rtl/fir_seq_ctrl_if.sv | 20 ++
 rtl/fir_ring_idx.sv | 18 +
 rtl/fir_seq_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_fir_seq_ctrl.sv | 379 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR control sequencer.
package fir_pkg;

   localparam int unsigned TAPS       = 11;
   localparam int unsigned ADDR_SHIFT = 2;

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StWaitIn,
      StMac,
      StOut,
      StDone
   } fir_state_e;

   // Word index to BRAM byte address.
   function automatic logic [31:0] idx_to_addr(input logic [7:0] idx);
      return {24'd0, idx} << ADDR_SHIFT;
   endfunction

endpackage

// File: rtl/fir_seq_ctrl_if.sv
// AXI-Stream handshake bundle (valid/ready/last) used for both sample input and result output.
interface fir_seq_ctrl_if;

   logic tvalid;
   logic tready;
   logic tlast;

   modport master (
      output tvalid,
      output tlast,
      input  tready
   );

   modport slave (
      input  tvalid,
      input  tlast,
      output tready
   );

endinterface

// File: rtl/fir_ring_idx.sv
// Modulo-Tape_Num index arithmetic for the circular data buffer.
module fir_ring_idx #(
   parameter int unsigned Tape_Num = 11,
   parameter int unsigned IdxW     = 4
) (
   input  logic [IdxW-1:0] base,
   input  logic [IdxW-1:0] sub,
   output logic [IdxW-1:0] diff,
   output logic [IdxW-1:0] inc
);

   // Widen by one bit so base + Tape_Num cannot overflow before the subtract.
   assign diff = (base >= sub) ? (base - sub)
                               : IdxW'({1'b0, base} + (IdxW + 1)'(Tape_Num) - {1'b0, sub});

   assign inc = (base == IdxW'(Tape_Num - 1)) ? '0 : base + 1'b1;

endmodule

// File: rtl/fir_seq_ctrl.sv
// Control sequencer for the single-MAC FIR engine: ap lifecycle, BRAM addressing, MAC sequencing.
// Build option FIR_TLAST_CHK_EN adds a sticky tlast_err flag for misplaced ss_tlast.
module fir_seq_ctrl
   import fir_pkg::*;
#(
   parameter int unsigned pADDR_WIDTH = 12,
   parameter int unsigned Tape_Num    = TAPS
) (
   input  logic                   axis_clk,
   input  logic                   axis_rst_n,
   input  logic                   ap_start,
   input  logic [31:0]            data_length,
   input  logic                   ap_done_clr,
   output logic                   ap_idle,
   output logic                   ap_done,
`ifdef FIR_TLAST_CHK_EN
   output logic                   tlast_err,
`endif
   fir_seq_ctrl_if.slave          ss,
   fir_seq_ctrl_if.master         sm,
   output logic                   tap_own,
   output logic                   tap_EN,
   output logic [pADDR_WIDTH-1:0] tap_A,
   output logic                   data_EN,
   output logic [3:0]             data_WE,
   output logic [pADDR_WIDTH-1:0] data_A,
   output logic                   data_zero,
   output logic                   mac_clr,
   output logic                   mac_en,
   output logic                   sm_load
);

   // k counts 0..Tape_Num+1 in MAC: Tape_Num reads, one trailing mac_en, one sm_load.
   localparam int unsigned IdxW = $clog2(Tape_Num + 2);

   fir_state_e      state_q, state_d;
   logic [31:0]     len_q, len_d;
   logic [31:0]     cnt_q, cnt_d;
   logic [IdxW-1:0] wptr_q, wptr_d;
   logic [IdxW-1:0] k_q, k_d;
   logic [IdxW-1:0] wptr_inc;
   logic [IdxW-1:0] rd_idx;
   logic            ap_idle_q, ap_done_q;
   logic            start_run;
   logic            last_out;
   logic            ss_tready;
   logic            sm_tvalid;
   logic            sm_tlast;

   fir_ring_idx #(
      .Tape_Num (Tape_Num),
      .IdxW     (IdxW)
   ) u_ring_idx (
      .base (wptr_q),
      .sub  (k_q),
      .diff (rd_idx),
      .inc  (wptr_inc)
   );

   assign start_run = (state_q == StIdle) && ap_start && (data_length != 32'd0);
   assign last_out  = (cnt_q == len_q);

   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         state_q <= StIdle;
         len_q   <= '0;
         cnt_q   <= '0;
         wptr_q  <= '0;
         k_q     <= '0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         cnt_q   <= cnt_d;
         wptr_q  <= wptr_d;
         k_q     <= k_d;
      end
   end

   // ap_done is sticky; a set in DONE beats a coincident clear.
   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         ap_idle_q <= 1'b1;
         ap_done_q <= 1'b0;
      end else begin
         if (start_run) begin
            ap_idle_q <= 1'b0;
         end else if (state_q == StDone) begin
            ap_idle_q <= 1'b1;
         end
         if (state_q == StDone) begin
            ap_done_q <= 1'b1;
         end else if (ap_done_clr) begin
            ap_done_q <= 1'b0;
         end
      end
   end

   assign ap_idle = ap_idle_q;
   assign ap_done = ap_done_q;

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      cnt_d   = cnt_q;
      wptr_d  = wptr_q;
      k_d     = k_q;
      unique case (state_q)
         StIdle: begin
            if (ap_start) begin
               if (data_length != 32'd0) begin
                  len_d   = data_length;
                  k_d     = '0;
                  state_d = StClear;
               end else begin
                  state_d = StDone;
               end
            end
         end
         StClear: begin
            if (k_q == IdxW'(Tape_Num - 1)) begin
               k_d     = '0;
               wptr_d  = '0;
               cnt_d   = '0;
               state_d = StWaitIn;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         StWaitIn: begin
            if (ss.tvalid) begin
               k_d     = '0;
               state_d = StMac;
            end
         end
         StMac: begin
            if (k_q == IdxW'(Tape_Num + 1)) begin
               k_d     = '0;
               wptr_d  = wptr_inc;
               cnt_d   = cnt_q + 32'd1;
               state_d = StOut;
            end else begin
               k_d = k_q + 1'b1;
            end
         end
         StOut: begin
            if (sm.tready) begin
               state_d = last_out ? StDone : StWaitIn;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_comb begin
      ss_tready = 1'b0;
      sm_tvalid = 1'b0;
      sm_tlast  = 1'b0;
      tap_own   = 1'b0;
      tap_EN    = 1'b0;
      tap_A     = '0;
      data_EN   = 1'b0;
      data_WE   = 4'h0;
      data_A    = '0;
      data_zero = 1'b0;
      mac_clr   = 1'b0;
      mac_en    = 1'b0;
      sm_load   = 1'b0;
      unique case (state_q)
         StClear: begin
            tap_own   = 1'b1;
            data_EN   = 1'b1;
            data_WE   = 4'hF;
            data_zero = 1'b1;
            data_A    = pADDR_WIDTH'(idx_to_addr(8'(k_q)));
         end
         StWaitIn: begin
            tap_own   = 1'b1;
            ss_tready = 1'b1;
            data_EN   = ss.tvalid;
            data_WE   = ss.tvalid ? 4'hF : 4'h0;
            data_A    = pADDR_WIDTH'(idx_to_addr(8'(wptr_q)));
         end
         StMac: begin
            tap_own = 1'b1;
            if (k_q < IdxW'(Tape_Num)) begin
               tap_EN  = 1'b1;
               data_EN = 1'b1;
               tap_A   = pADDR_WIDTH'(idx_to_addr(8'(k_q)));
               data_A  = pADDR_WIDTH'(idx_to_addr(8'(rd_idx)));
            end
            // Accumulate trails each read by the 1-cycle BRAM latency.
            mac_en  = (k_q != '0) && (k_q <= IdxW'(Tape_Num));
            mac_clr = (k_q == IdxW'(1));
            sm_load = (k_q == IdxW'(Tape_Num + 1));
         end
         StOut: begin
            tap_own   = 1'b1;
            sm_tvalid = 1'b1;
            sm_tlast  = last_out;
         end
         default: begin
         end
      endcase
   end

   assign ss.tready = ss_tready;
   assign sm.tvalid = sm_tvalid;
   assign sm.tlast  = sm_tlast;

`ifdef FIR_TLAST_CHK_EN
   logic tlast_err_q;
   logic sample_is_last;

   assign sample_is_last = ((cnt_q + 32'd1) == len_q);

   always_ff @(posedge axis_clk or negedge axis_rst_n) begin
      if (!axis_rst_n) begin
         tlast_err_q <= 1'b0;
      end else if ((state_q == StWaitIn) && ss.tvalid && (ss.tlast != sample_is_last)) begin
         tlast_err_q <= 1'b1;
      end else if ((state_q == StIdle) && ap_start) begin
         tlast_err_q <= 1'b0;
      end
   end

   assign tlast_err = tlast_err_q;
`endif

endmodule

// File: tb/tb_fir_seq_ctrl.sv
// Scoreboard bench for fir_seq_ctrl with behavioural tap/data BRAMs and MAC datapath.
module tb_fir_seq_ctrl;

   localparam int AW = 12;
   localparam int H [11] = '{0, -10, -9, 23, 56, 63, 56, 23, -9, -10, 0};

   typedef struct {
      int data;
      bit last;
   } exp_t;

   logic          axis_clk;
   logic          axis_rst_n;
   logic          ap_start;
   logic [31:0]   data_length;
   logic          ap_done_clr;
   logic          ap_idle;
   logic          ap_done;
   logic          tap_own;
   logic          tap_EN;
   logic [AW-1:0] tap_A;
   logic          data_EN;
   logic [3:0]    data_WE;
   logic [AW-1:0] data_A;
   logic          data_zero;
   logic          mac_clr;
   logic          mac_en;
   logic          sm_load;
`ifdef FIR_TLAST_CHK_EN
   logic          tlast_err;
`endif

   fir_seq_ctrl_if ss_if ();
   fir_seq_ctrl_if sm_if ();

   fir_seq_ctrl #(
      .pADDR_WIDTH (AW),
      .Tape_Num    (11)
   ) dut (
      .axis_clk    (axis_clk),
      .axis_rst_n  (axis_rst_n),
      .ap_start    (ap_start),
      .data_length (data_length),
      .ap_done_clr (ap_done_clr),
      .ap_idle     (ap_idle),
      .ap_done     (ap_done),
`ifdef FIR_TLAST_CHK_EN
      .tlast_err   (tlast_err),
`endif
      .ss          (ss_if),
      .sm          (sm_if),
      .tap_own     (tap_own),
      .tap_EN      (tap_EN),
      .tap_A       (tap_A),
      .data_EN     (data_EN),
      .data_WE     (data_WE),
      .data_A      (data_A),
      .data_zero   (data_zero),
      .mac_clr     (mac_clr),
      .mac_en      (mac_en),
      .sm_load     (sm_load)
   );

   int n_pass = 0;
   int n_total = 0;
   int cyc = 0;
   int ss_tdata;
   int data_mem [11];
   int tap_q, data_q, acc, sm_tdata;
   exp_t exp_q [$];
   exp_t mon_e;
   int out_cnt = 0;
   int n_sent = 0;
   int first_acc = -1;
   int first_vld = -1;
   int stall_left = 0;
   bit stall_done = 0;
   bit stall_active = 0;
   int stall_data = 0;
   int stall_cyc = 0;
   int stall_bad = 0;
   int mac_en_cnt = 0;
   int mac_clr_cnt = 0;
   int sm_load_cnt = 0;
   int clr_tr [$];
   int wr_tr [$];
   int tap_tr [$];
   int rd_tr [$];

   initial begin
      axis_clk = 1'b0;
      forever #5 axis_clk = ~axis_clk;
   end

   always @(posedge axis_clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
   endtask

   task automatic note_fail(input string name);
      n_total++;
      $display("FAIL %s: event not seen within its cycle budget", name);
   endtask

   function automatic int aidx(input logic [AW-1:0] a);
      int i;
      i = int'(a >> 2);
      return (i > 10) ? 10 : i;
   endfunction

   // Behavioural BRAM pair (1-cycle read) and MAC datapath driven by the sequencer.
   always @(posedge axis_clk) begin
      if (tap_EN) tap_q <= H[aidx(tap_A)];
      if (data_EN) begin
         if (data_WE == 4'hF) data_mem[aidx(data_A)] <= data_zero ? 0 : ss_tdata;
         else data_q <= data_mem[aidx(data_A)];
      end
      if (mac_en) acc <= mac_clr ? tap_q * data_q : acc + tap_q * data_q;
      if (sm_load) sm_tdata <= acc;
   end

   // Address/control trace.
   always @(negedge axis_clk) begin
      if (axis_rst_n) begin
         if (data_EN && data_zero) clr_tr.push_back(int'(data_A));
         if (data_EN && data_WE == 4'hF && !data_zero) wr_tr.push_back(int'(data_A));
         if (data_EN && data_WE == 4'h0) rd_tr.push_back(int'(data_A));
         if (tap_EN) tap_tr.push_back(int'(tap_A));
         if (mac_en) mac_en_cnt++;
         if (mac_en && mac_clr) mac_clr_cnt++;
         if (sm_load) sm_load_cnt++;
      end
   end

   // Output monitor: pops the scoreboard on every sm handshake.
   always @(negedge axis_clk) begin
      if (axis_rst_n) begin
         if (sm_if.tvalid && first_vld < 0) first_vld = cyc;
         if (stall_active) begin
            stall_cyc++;
            if (!sm_if.tvalid || sm_tdata != stall_data || ss_if.tready) stall_bad++;
         end
         if (sm_if.tvalid && sm_if.tready) begin
            if (exp_q.size() == 0) begin
               note_fail("unexpected_output");
            end else begin
               mon_e = exp_q.pop_front();
               chk($sformatf("sm_tdata[%0d]", out_cnt), sm_tdata, mon_e.data);
               chk($sformatf("sm_tlast[%0d]", out_cnt), sm_if.tlast, mon_e.last);
            end
            out_cnt++;
         end
      end
   end

   // Downstream ready: light periodic backpressure plus one 20-cycle stall on output 4.
   initial begin
      sm_if.tready = 1'b0;
      forever begin
         @(posedge axis_clk);
         #1;
         if (!stall_done && out_cnt == 4 && sm_if.tvalid) begin
            stall_left = 20;
            stall_done = 1;
            stall_data = sm_tdata;
         end
         if (stall_left > 0) begin
            sm_if.tready = 1'b0;
            stall_active = 1;
            stall_left--;
         end else begin
            stall_active = 0;
            sm_if.tready = (cyc % 5) != 2;
         end
      end
   end

   task automatic start(input int len);
      ap_start = 1'b1;
      data_length = len;
      @(posedge axis_clk);
      #1;
      ap_start = 1'b0;
   endtask

   task automatic send(input int x, input bit last);
      int n = 0;
      ss_tdata = x;
      ss_if.tvalid = 1'b1;
      ss_if.tlast = last;
      @(negedge axis_clk);
      while (!ss_if.tready && n < 400) begin
         @(negedge axis_clk);
         n++;
      end
      if (!ss_if.tready) note_fail("ss_accept_timeout");
      else if (first_acc < 0) first_acc = cyc;
      if (ss_if.tready) n_sent++;
      @(posedge axis_clk);
      #1;
      ss_if.tvalid = 1'b0;
      ss_if.tlast = 1'b0;
   endtask

   task automatic send_run(input int len, input int kind, input int bad);
      int hist [11];
      for (int k = 0; k < 11; k++) hist[k] = 0;
      for (int i = 0; i < len; i++) begin
         int x, y, m;
         exp_t e;
         m = i % 64;
         if (kind == 0) x = ((m < 32) ? m : 63 - m) * 8 - 100;
         else x = 1000 - 77 * i;
         for (int k = 10; k > 0; k--) hist[k] = hist[k - 1];
         hist[0] = x;
         y = 0;
         for (int k = 0; k < 11; k++) y += H[k] * hist[k];
         e.data = y;
         e.last = (i == len - 1);
         exp_q.push_back(e);
         if (len == 600 && i == 100) begin
            ap_start = 1'b1;
            data_length = 5;
            @(posedge axis_clk);
            #1;
            ap_start = 1'b0;
         end
         send(x, (i == len - 1) || (i + 1 == bad));
      end
   endtask

   task automatic wait_last(input int budget);
      int n = 0;
      bit seen = 0;
      while (!seen && n < budget) begin
         @(negedge axis_clk);
         seen = sm_if.tvalid && sm_if.tready && sm_if.tlast;
         n++;
      end
      if (!seen) note_fail("last_output_timeout");
      @(posedge axis_clk);
      #1;
   endtask

   initial begin
      int bad;
      axis_rst_n = 1'b0;
      ap_start = 1'b0;
      data_length = 0;
      ap_done_clr = 1'b0;
      ss_if.tvalid = 1'b0;
      ss_if.tlast = 1'b0;
      ss_tdata = 0;
      repeat (3) @(posedge axis_clk);
      @(negedge axis_clk);
      chk("rst_ap_idle", ap_idle, 1);
      chk("rst_ap_done", ap_done, 0);
      chk("rst_sm_tvalid", sm_if.tvalid, 0);
      @(posedge axis_clk);
      #1;
      axis_rst_n = 1'b1;

      bad = 0;
      for (int i = 0; i < 100; i++) begin
         @(negedge axis_clk);
         if (!ap_idle || ap_done || ss_if.tready || tap_EN || data_EN || tap_own || mac_en ||
             sm_if.tvalid) bad++;
      end
      chk("idle_window_violations", bad, 0);
      chk("idle_ss_tready", ss_if.tready, 0);

      // Run 1: 600 samples with mid-run ap_start, one long stall and clr coinciding with DONE.
      @(posedge axis_clk);
      #1;
      start(600);
      @(negedge axis_clk);
      chk("clear_ap_idle", ap_idle, 0);
      chk("clear_tap_own", tap_own, 1);
      chk("clear_ss_tready", ss_if.tready, 0);
      chk("clear_data_zero", data_zero, 1);
      chk("clear_data_WE", data_WE, 15);
      @(posedge axis_clk);
      #1;
      send_run(600, 0, 0);
      wait_last(400);
      ap_done_clr = 1'b1;
      @(posedge axis_clk);
      #1;
      ap_done_clr = 1'b0;
      @(negedge axis_clk);
      chk("run1_ap_done", ap_done, 1);
      chk("run1_ap_idle", ap_idle, 1);
      chk("run1_tap_own", tap_own, 0);
      chk("run1_out_cnt", out_cnt, 600);

      chk("clr_count", clr_tr.size(), 11);
      for (int i = 0; i < 11; i++) chk($sformatf("clr_addr[%0d]", i), clr_tr[i], 4 * i);
      chk("wr_addr[0]", wr_tr[0], 0);
      chk("wr_addr[1]", wr_tr[1], 4);
      chk("wr_addr[11]", wr_tr[11], 0);
      for (int i = 0; i < 11; i++) chk($sformatf("tap_addr[%0d]", i), tap_tr[i], 4 * i);
      chk("rd_addr[0]", rd_tr[0], 0);
      for (int i = 1; i < 11; i++) chk($sformatf("rd_addr[%0d]", i), rd_tr[i], 4 * (11 - i));
      chk("rd2_addr[0]", rd_tr[11], 4);
      chk("rd2_addr[1]", rd_tr[12], 0);
      chk("rd2_addr[2]", rd_tr[13], 40);
      chk("latency_accept_to_valid", first_vld - first_acc, 14);
      chk("stall_cycles", stall_cyc, 20);
      chk("stall_violations", stall_bad, 0);

      @(posedge axis_clk);
      #1;
      ap_done_clr = 1'b1;
      @(posedge axis_clk);
      #1;
      ap_done_clr = 1'b0;
      @(negedge axis_clk);
      chk("done_cleared", ap_done, 0);

      // Zero-length start goes straight to DONE.
      @(posedge axis_clk);
      #1;
      start(0);
      @(posedge axis_clk);
      #1;
      @(negedge axis_clk);
      chk("len0_ap_done", ap_done, 1);
      chk("len0_ap_idle", ap_idle, 1);
      chk("len0_no_clear", clr_tr.size(), 11);
      @(posedge axis_clk);
      #1;
      ap_done_clr = 1'b1;
      @(posedge axis_clk);
      #1;
      ap_done_clr = 1'b0;
      clr_tr.delete();

      // Run 2: short run; stale run-1 data must have been cleared.
      start(3);
      send_run(3, 1, 0);
      wait_last(400);
      @(posedge axis_clk);
      #1;
      @(negedge axis_clk);
      chk("run2_clr_count", clr_tr.size(), 11);
      chk("run2_ap_done", ap_done, 1);
      chk("run2_out_cnt", out_cnt, 603);
`ifdef FIR_TLAST_CHK_EN
      chk("tlast_err_good_run", tlast_err, 0);
      @(posedge axis_clk);
      #1;
      start(5);
      send_run(5, 1, 3);
      wait_last(400);
      @(negedge axis_clk);
      chk("tlast_err_flagged", tlast_err, 1);
      chk("tlast_run_out_cnt", out_cnt, 608);
`endif

      chk("all_outputs_seen", out_cnt, n_sent);
      chk("scoreboard_empty", exp_q.size(), 0);
      chk("mac_en_total", mac_en_cnt, 11 * n_sent);
      chk("mac_clr_total", mac_clr_cnt, n_sent);
      chk("sm_load_total", sm_load_cnt, n_sent);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation time limit reached, %0d/%0d", n_pass, n_total);
      $fatal(1, "watchdog");
   end

endmodule
